// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver FSM states and small bit-level helpers.
package uart_rx_cfg_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rxState_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // xorAll is the XOR of every data bit and the received parity bit
  function automatic logic parity_err(input int unsigned mode, input logic xorAll);
    if (mode == PAR_EVEN) return xorAll;
    if (mode == PAR_ODD)  return ~xorAll;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver: 2-FF synchroniser on the raw
// line and a 3-sample majority vote around the bit centre.
module uart_rx_sampler
  import uart_rx_cfg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx,
  input  logic [CNT_W-1:0] i_bitCnt,
  output logic             o_syncRx,
  output logic             o_bitVal
);

  localparam int unsigned      CENTRE     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] PRE_CENTRE = CNT_W'(CENTRE - 1);

  logic sync1;
  logic sync2;
  logic earlySample;

  // Two-stage synchroniser, idle-high after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_rx;
      sync2 <= sync1;
    end
  end

  // Hold the sample taken one clock before the bit centre
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      earlySample <= 1'b1;
    end else if (i_bitCnt == PRE_CENTRE) begin
      earlySample <= sync2;
    end
  end

  assign o_syncRx = sync2;
  // sync1 already holds the value sync2 shows on the next clock, so the
  // C+1 sample is available at the centre and the vote lands at C.
  assign o_bitVal = majority3(earlySample, sync2, sync1);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional even/odd parity,
// 1 or 2 stop bits, majority-voted sampling, parity/framing/break flags.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 217,
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned PARITY_MODE   = 0,
  parameter int unsigned NUM_STOP_BITS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rx,
  output logic                     o_rxcFlag,
  output logic [NUM_DATA_BITS-1:0] o_rxByte,
  output logic                     o_parityErr,
  output logic                     o_frameErr,
  output logic                     o_break,
  output logic                     o_busy
);

  localparam int unsigned      CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int unsigned      IDX_W      = $clog2(NUM_DATA_BITS + 1);
  localparam int unsigned      CENTRE     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_CENTRE = CNT_W'(CENTRE);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DATA_BITS - 1);
  localparam logic             STOP_LAST  = 1'(NUM_STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY_MODE != PAR_NONE);

  rxState_t                 state;
  rxState_t                 stateNext;
  logic [CNT_W-1:0]         bitCnt;
  logic [IDX_W-1:0]         bitIdx;
  logic [NUM_DATA_BITS-1:0] shReg;
  logic                     stopIdx;
  logic                     allZero;
  logic                     frameErrAcc;
  logic                     parErrAcc;
  logic                     syncRx;
  logic                     bitVal;
  logic                     atCentre;
  logic                     startOk;
  logic                     shiftEn;
  logic                     parEn;
  logic                     stopEn;
  logic                     frameDone;
  logic                     brkNow;
  logic                     frameNow;

  uart_rx_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_sampler (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_rx     (i_rx),
    .i_bitCnt (bitCnt),
    .o_syncRx (syncRx),
    .o_bitVal (bitVal)
  );

  assign atCentre = (bitCnt == CNT_CENTRE);
  assign o_busy   = (state != ST_IDLE) && (state != ST_START);

  // Break needs every data/parity bit and the first stop bit low; for one
  // stop bit that first stop bit is the one being voted right now.
  assign brkNow   = allZero & (stopIdx | ~bitVal);
  assign frameNow = frameErrAcc | ~bitVal;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= stateNext;
  end

  // Next-state and per-bit strobes
  always_comb begin
    stateNext = state;
    startOk   = 1'b0;
    shiftEn   = 1'b0;
    parEn     = 1'b0;
    stopEn    = 1'b0;
    frameDone = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!syncRx) stateNext = ST_START;
      end
      ST_START: begin
        if (atCentre) begin
          if (!bitVal) begin
            startOk   = 1'b1;
            stateNext = ST_DATA;
          end else begin
            stateNext = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (atCentre) begin
          shiftEn = 1'b1;
          if (bitIdx == IDX_LAST) stateNext = HAS_PARITY ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (atCentre) begin
          parEn     = 1'b1;
          stateNext = ST_STOP;
        end
      end
      ST_STOP: begin
        if (atCentre) begin
          stopEn = 1'b1;
          if (stopIdx == STOP_LAST) begin
            frameDone = 1'b1;
            stateNext = bitVal ? ST_IDLE : ST_BRK_WAIT;
          end
        end
      end
      ST_BRK_WAIT: begin
        if (syncRx) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Bit-period counter; the IDLE cycle that sees the start edge counts as
  // position 0, so START begins at 1 and bitCnt lines up with line time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bitCnt <= '0;
    end else if (state == ST_IDLE) begin
      bitCnt <= syncRx ? '0 : CNT_W'(1);
    end else if (bitCnt == CNT_LAST) begin
      bitCnt <= '0;
    end else begin
      bitCnt <= bitCnt + CNT_W'(1);
    end
  end

  // Frame accumulation: shift register, bit/stop indices, error tracking
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bitIdx      <= '0;
      shReg       <= '0;
      stopIdx     <= 1'b0;
      allZero     <= 1'b0;
      frameErrAcc <= 1'b0;
      parErrAcc   <= 1'b0;
    end else begin
      if (startOk) begin
        bitIdx      <= '0;
        stopIdx     <= 1'b0;
        allZero     <= 1'b1;
        frameErrAcc <= 1'b0;
        parErrAcc   <= 1'b0;
      end
      if (shiftEn) begin
        shReg   <= {bitVal, shReg[NUM_DATA_BITS-1:1]};
        bitIdx  <= bitIdx + IDX_W'(1);
        allZero <= allZero & ~bitVal;
      end
      if (parEn) begin
        parErrAcc <= parity_err(PARITY_MODE, (^shReg) ^ bitVal);
        allZero   <= allZero & ~bitVal;
      end
      if (stopEn) begin
        stopIdx     <= 1'b1;
        frameErrAcc <= frameNow;
        if (!stopIdx) allZero <= allZero & ~bitVal;
      end
    end
  end

  // Output registers, updated once per frame at the last stop-bit centre
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rxcFlag   <= 1'b0;
      o_rxByte    <= '0;
      o_parityErr <= 1'b0;
      o_frameErr  <= 1'b0;
      o_break     <= 1'b0;
    end else begin
      o_rxcFlag <= frameDone;
      if (frameDone) begin
        o_rxByte    <= brkNow ? '0 : shReg;
        o_parityErr <= parErrAcc;
        o_frameErr  <= frameNow | brkNow;
        o_break     <= brkNow;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) driven bit by bit,
// expected frames queued at stimulus time and compared as frames complete.
module tb_uart_rx_cfg;

  localparam int unsigned CPB = 217;
  localparam int unsigned C   = (CPB - 1) / 2;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [2:0] rx;

  logic       flag0, pe0, fe0, brk0, busy0;
  logic [7:0] byte0;
  logic       flag1, pe1, fe1, brk1, busy1;
  logic [6:0] byte1;
  logic       flag2, pe2, fe2, brk2, busy2;
  logic [7:0] byte2;

  uart_rx_cfg #(
    .CLKS_PER_BIT (CPB), .NUM_DATA_BITS (8), .PARITY_MODE (0), .NUM_STOP_BITS (1)
  ) dut0 (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_rx (rx[0]), .o_rxcFlag (flag0),
    .o_rxByte (byte0), .o_parityErr (pe0), .o_frameErr (fe0), .o_break (brk0), .o_busy (busy0)
  );

  uart_rx_cfg #(
    .CLKS_PER_BIT (CPB), .NUM_DATA_BITS (7), .PARITY_MODE (1), .NUM_STOP_BITS (1)
  ) dut1 (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_rx (rx[1]), .o_rxcFlag (flag1),
    .o_rxByte (byte1), .o_parityErr (pe1), .o_frameErr (fe1), .o_break (brk1), .o_busy (busy1)
  );

  uart_rx_cfg #(
    .CLKS_PER_BIT (CPB), .NUM_DATA_BITS (8), .PARITY_MODE (0), .NUM_STOP_BITS (2)
  ) dut2 (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_rx (rx[2]), .o_rxcFlag (flag2),
    .o_rxByte (byte2), .o_parityErr (pe2), .o_frameErr (fe2), .o_break (brk2), .o_busy (busy2)
  );

  typedef struct {
    int unsigned d;
    logic [8:0]  data;
    logic        pe;
    logic        fe;
    logic        brk;
    int unsigned cyc;
  } obs_t;

  typedef struct {
    int unsigned d;
    logic [8:0]  data;
    logic        pe;
    logic        fe;
    logic        brk;
  } exp_t;

  obs_t        obsQ[$];
  exp_t        expQ[$];
  int          obsRd    = 0;
  int          checks   = 0;
  int          errors   = 0;
  int unsigned cyc      = 0;
  int unsigned busyCnt0 = 0;

  always #5 i_clk = ~i_clk;

  // Free-running posedge counter for latency measurement
  always @(posedge i_clk) cyc <= cyc + 1;

  // Capture every completed frame from all instances, plus dut0 busy cycles
  always @(negedge i_clk) begin
    if (flag0) obsQ.push_back('{0, {1'b0, byte0}, pe0, fe0, brk0, cyc});
    if (flag1) obsQ.push_back('{1, {2'b00, byte1}, pe1, fe1, brk1, cyc});
    if (flag2) obsQ.push_back('{2, {1'b0, byte2}, pe2, fe2, brk2, cyc});
    if (busy0) busyCnt0 <= busyCnt0 + 1;
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_level(input int d, input logic lvl, input int unsigned n);
    rx[d] = lvl;
    repeat (n) tick;
  endtask

  // bits[0] is the start bit; the rest go out in order, one bit time each
  task automatic drive_frame(input int d, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) drive_level(d, bits[i], CPB);
  endtask

  task automatic get_obs(output obs_t o, output bit ok);
    int unsigned waited = 0;
    ok = 1'b0;
    o  = '{0, 9'h0, 1'b0, 1'b0, 1'b0, 0};
    while (!ok && waited < 4 * CPB) begin
      if (obsQ.size() > obsRd) begin
        o = obsQ[obsRd];
        obsRd++;
        ok = 1'b1;
      end else begin
        tick;
        waited++;
      end
    end
  endtask

  task automatic test_reset;
    rx      = '1;
    i_rst_n = 1'b0;
    repeat (5) tick;
    checks++;
    if ({flag0, byte0, pe0, fe0, brk0, busy0} !== 13'h0) begin
      errors++;
      $display("FAIL reset_dut0: outputs=%h required 0", {flag0, byte0, pe0, fe0, brk0, busy0});
    end
    checks++;
    if ({flag1, byte1, pe1, fe1, brk1, busy1} !== 12'h0) begin
      errors++;
      $display("FAIL reset_dut1: outputs=%h required 0", {flag1, byte1, pe1, fe1, brk1, busy1});
    end
    checks++;
    if ({flag2, byte2, pe2, fe2, brk2, busy2} !== 13'h0) begin
      errors++;
      $display("FAIL reset_dut2: outputs=%h required 0", {flag2, byte2, pe2, fe2, brk2, busy2});
    end
    i_rst_n = 1'b1;
    repeat (3) tick;
  endtask

  task automatic test_basic;
    obs_t        o;
    exp_t        e;
    bit          ok;
    int unsigned startCyc;
    expQ.push_back('{0, 9'h037, 1'b0, 1'b0, 1'b0});
    startCyc = cyc;
    drive_frame(0, {6'h3F, 1'b1, 8'h37, 1'b0}, 10);
    rx[0] = 1'b1;
    get_obs(o, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || o.d != e.d || {o.data, o.pe, o.fe, o.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
      errors++;
      $display("FAIL basic_0x37: ok=%0b dut%0d data=%h pe=%b fe=%b brk=%b, required dut%0d data=%h pe=%b fe=%b brk=%b",
               ok, o.d, o.data, o.pe, o.fe, o.brk, e.d, e.data, e.pe, e.fe, e.brk);
    end
    checks++;
    if (!ok || (o.cyc - startCyc) != 3 + C + 9 * CPB) begin
      errors++;
      $display("FAIL basic_latency: got %0d clocks, required %0d", o.cyc - startCyc, 3 + C + 9 * CPB);
    end
    drive_level(0, 1'b1, 4);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_idle: busy=%b required 0", busy0);
    end
  endtask

  task automatic test_glitch;
    int unsigned busyBefore;
    int          nBefore;
    busyBefore = busyCnt0;
    nBefore    = obsQ.size();
    drive_level(0, 1'b0, 50);
    drive_level(0, 1'b1, 3 * CPB);
    checks++;
    if (obsQ.size() != nBefore) begin
      errors++;
      $display("FAIL glitch_no_frame: frames=%0d required %0d", obsQ.size(), nBefore);
    end
    checks++;
    if (busyCnt0 != busyBefore) begin
      errors++;
      $display("FAIL glitch_busy: busy cycles=%0d required 0", busyCnt0 - busyBefore);
    end
  endtask

  task automatic test_frame_err;
    obs_t o;
    exp_t e;
    bit   ok;
    expQ.push_back('{0, 9'h0A5, 1'b0, 1'b1, 1'b0});
    drive_frame(0, {6'h00, 1'b0, 8'hA5, 1'b0}, 10);
    rx[0] = 1'b1;
    get_obs(o, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || o.d != e.d || {o.data, o.pe, o.fe, o.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
      errors++;
      $display("FAIL stop_low_0xA5: ok=%0b dut%0d data=%h pe=%b fe=%b brk=%b, required dut%0d data=%h pe=%b fe=%b brk=%b",
               ok, o.d, o.data, o.pe, o.fe, o.brk, e.d, e.data, e.pe, e.fe, e.brk);
    end
    drive_level(0, 1'b1, 2 * CPB);
  endtask

  task automatic test_break;
    obs_t o;
    exp_t e;
    bit   ok;
    expQ.push_back('{0, 9'h000, 1'b0, 1'b1, 1'b1});
    drive_level(0, 1'b0, 20 * CPB);
    rx[0] = 1'b1;
    get_obs(o, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || o.d != e.d || {o.data, o.pe, o.fe, o.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
      errors++;
      $display("FAIL break: ok=%0b dut%0d data=%h pe=%b fe=%b brk=%b, required dut%0d data=%h pe=%b fe=%b brk=%b",
               ok, o.d, o.data, o.pe, o.fe, o.brk, e.d, e.data, e.pe, e.fe, e.brk);
    end
    drive_level(0, 1'b1, 3 * CPB);
    checks++;
    if (obsQ.size() != obsRd) begin
      errors++;
      $display("FAIL break_single_report: frames=%0d required %0d", obsQ.size(), obsRd);
    end
    expQ.push_back('{0, 9'h012, 1'b0, 1'b0, 1'b0});
    drive_frame(0, {6'h3F, 1'b1, 8'h12, 1'b0}, 10);
    rx[0] = 1'b1;
    get_obs(o, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || o.d != e.d || {o.data, o.pe, o.fe, o.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
      errors++;
      $display("FAIL after_break_0x12: ok=%0b dut%0d data=%h pe=%b fe=%b brk=%b, required dut%0d data=%h pe=%b fe=%b brk=%b",
               ok, o.d, o.data, o.pe, o.fe, o.brk, e.d, e.data, e.pe, e.fe, e.brk);
    end
  endtask

  task automatic test_parity;
    obs_t       o;
    exp_t       e;
    bit         ok;
    logic [6:0] dat[3];
    logic       par[3];
    logic       perr[3];
    dat  = '{7'h55, 7'h55, 7'h13};
    par  = '{1'b0, 1'b1, 1'b1};
    perr = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      expQ.push_back('{1, {2'b00, dat[i]}, perr[i], 1'b0, 1'b0});
      drive_frame(1, {6'h3F, 1'b1, par[i], dat[i], 1'b0}, 10);
      rx[1] = 1'b1;
      get_obs(o, ok);
      e = expQ.pop_front();
      checks++;
      if (!ok || o.d != e.d || {o.data, o.pe, o.fe, o.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
        errors++;
        $display("FAIL parity_case%0d: ok=%0b dut%0d data=%h pe=%b fe=%b brk=%b, required dut%0d data=%h pe=%b fe=%b brk=%b",
                 i, ok, o.d, o.data, o.pe, o.fe, o.brk, e.d, e.data, e.pe, e.fe, e.brk);
      end
      drive_level(1, 1'b1, CPB);
    end
  endtask

  task automatic test_stop2;
    obs_t o;
    exp_t e;
    bit   ok;
    expQ.push_back('{2, 9'h03C, 1'b0, 1'b1, 1'b0});
    drive_frame(2, {5'h00, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    rx[2] = 1'b1;
    get_obs(o, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || o.d != e.d || {o.data, o.pe, o.fe, o.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
      errors++;
      $display("FAIL stop2_low: ok=%0b dut%0d data=%h pe=%b fe=%b brk=%b, required dut%0d data=%h pe=%b fe=%b brk=%b",
               ok, o.d, o.data, o.pe, o.fe, o.brk, e.d, e.data, e.pe, e.fe, e.brk);
    end
    drive_level(2, 1'b1, 2 * CPB);
  endtask

  task automatic test_back_to_back;
    obs_t o;
    exp_t e;
    bit   ok;
    expQ.push_back('{2, 9'h000, 1'b0, 1'b0, 1'b0});
    expQ.push_back('{2, 9'h0FF, 1'b0, 1'b0, 1'b0});
    drive_frame(2, {5'h1F, 2'b11, 8'h00, 1'b0}, 11);
    drive_frame(2, {5'h1F, 2'b11, 8'hFF, 1'b0}, 11);
    rx[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      get_obs(o, ok);
      e = expQ.pop_front();
      checks++;
      if (!ok || o.d != e.d || {o.data, o.pe, o.fe, o.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
        errors++;
        $display("FAIL back_to_back_%0d: ok=%0b dut%0d data=%h pe=%b fe=%b brk=%b, required dut%0d data=%h pe=%b fe=%b brk=%b",
                 i, ok, o.d, o.data, o.pe, o.fe, o.brk, e.d, e.data, e.pe, e.fe, e.brk);
      end
    end
    drive_level(2, 1'b1, CPB);
  endtask

  task automatic test_noise;
    obs_t o;
    exp_t e;
    bit   ok;
    expQ.push_back('{0, 9'h000, 1'b0, 1'b0, 1'b0});
    drive_level(0, 1'b0, 4 * CPB);
    drive_level(0, 1'b0, C);
    drive_level(0, 1'b1, 1);
    drive_level(0, 1'b0, CPB - C - 1);
    drive_level(0, 1'b0, 4 * CPB);
    drive_level(0, 1'b1, CPB);
    get_obs(o, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || o.d != e.d || {o.data, o.pe, o.fe, o.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
      errors++;
      $display("FAIL mid_bit_noise: ok=%0b dut%0d data=%h pe=%b fe=%b brk=%b, required dut%0d data=%h pe=%b fe=%b brk=%b",
               ok, o.d, o.data, o.pe, o.fe, o.brk, e.d, e.data, e.pe, e.fe, e.brk);
    end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    exp_t e;
    bit   ok;
    expQ.push_back('{0, 9'h05A, 1'b0, 1'b0, 1'b0});
    drive_frame(0, {6'h3F, 1'b1, 8'h5A, 1'b0}, 10);
    rx[0] = 1'b1;
    get_obs(o, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || o.d != e.d || {o.data, o.pe, o.fe, o.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
      errors++;
      $display("FAIL pre_reset_0x5A: ok=%0b dut%0d data=%h pe=%b fe=%b brk=%b, required dut%0d data=%h pe=%b fe=%b brk=%b",
               ok, o.d, o.data, o.pe, o.fe, o.brk, e.d, e.data, e.pe, e.fe, e.brk);
    end
    drive_level(0, 1'b1, CPB);
    drive_frame(0, 16'b0000_0000_0000_0110, 3);
    drive_level(0, 1'b0, C);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_data: busy=%b required 1", busy0);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({flag0, byte0, pe0, fe0, brk0, busy0} !== 13'h0) begin
      errors++;
      $display("FAIL reset_mid_frame: outputs=%h required 0", {flag0, byte0, pe0, fe0, brk0, busy0});
    end
    rx[0] = 1'b1;
    repeat (3) tick;
    i_rst_n = 1'b1;
    drive_level(0, 1'b1, 2 * CPB);
    checks++;
    if (obsQ.size() != obsRd) begin
      errors++;
      $display("FAIL reset_no_pulse: frames=%0d required %0d", obsQ.size(), obsRd);
    end
    expQ.push_back('{0, 9'h0C3, 1'b0, 1'b0, 1'b0});
    drive_frame(0, {6'h3F, 1'b1, 8'hC3, 1'b0}, 10);
    rx[0] = 1'b1;
    get_obs(o, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || o.d != e.d || {o.data, o.pe, o.fe, o.brk} !== {e.data, e.pe, e.fe, e.brk}) begin
      errors++;
      $display("FAIL post_reset_0xC3: ok=%0b dut%0d data=%h pe=%b fe=%b brk=%b, required dut%0d data=%h pe=%b fe=%b brk=%b",
               ok, o.d, o.data, o.pe, o.fe, o.brk, e.d, e.data, e.pe, e.fe, e.brk);
    end
    drive_level(0, 1'b1, CPB);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_break;
    test_parity;
    test_stop2;
    test_back_to_back;
    test_noise;
    test_reset_mid;
    checks++;
    if (obsQ.size() != obsRd) begin
      errors++;
      $display("FAIL spurious_frames: %0d unexpected frame(s) required 0", obsQ.size() - obsRd);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
